vram_readback: RTL and testbench

C64-side read-back port for the video SRAM: the read direction of the cartridge register window whose writes feed the scanout engine's SRAM writes. It mirrors the token/address registers, prefetches the addressed byte through the SRAM arbiter's read slot, returns it on C64 reads of a data register, and post-increments the pointer. It sits between the cartridge port and the SRAM arbiter, in the fast clock domain.

---
 rtl/vram_readback.sv | 259 +++++++++++++++++++++++++
 tb/tb_vram_readback.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_readback.sv
// vram_readback: C64-side read-back window for the video SRAM.
// Mirrors the token/address registers, prefetches the addressed byte through
// the arbiter's read slot, serves it on DATA reads and post-increments the
// pointer. Runs entirely in the clk100 domain; PHI2 is synchronized here.
`timescale 1ns/1ps

module vram_readback #(
  parameter logic [15:0] BASE_ADDR   = 16'hDE00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        i_64clk,
  input  logic        i_64rw,
  input  logic [15:0] i_64addr,
  input  logic [7:0]  i_64data,
  output logic [7:0]  o_64data,
  output logic        o_64doe,
  output logic        o_rd_req,
  input  logic        i_rd_gnt,
  output logic [16:0] o_rd_addr,
  input  logic        i_rd_valid,
  input  logic [7:0]  i_rd_data,
  output logic        o_busy
);

  // Register offsets inside the window
  localparam logic [2:0] OFF_TOKEN  = 3'd0;
  localparam logic [2:0] OFF_ADDR_L = 3'd1;
  localparam logic [2:0] OFF_ADDR_H = 3'd2;
  localparam logic [2:0] OFF_OPER   = 3'd3;
  localparam logic [2:0] OFF_DATA   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  // Prefetch FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ---------------------------------------------------------------------------
  // PHI2 synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] phi2_sync_reg;
  logic                   phi2_prev_reg;
  logic                   phi2;
  logic                   phi2_rise;
  logic                   phi2_fall;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the asynchronous PHI2 directly
        always_ff @(posedge clk100 or posedge rst) begin
          if (rst) phi2_sync_reg[gi] <= 1'b0;
          else     phi2_sync_reg[gi] <= i_64clk;
        end
      end else begin : g_next
        // Later stages shift the sample along the chain
        always_ff @(posedge clk100 or posedge rst) begin
          if (rst) phi2_sync_reg[gi] <= 1'b0;
          else     phi2_sync_reg[gi] <= phi2_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign phi2      = phi2_sync_reg[SYNC_STAGES-1];
  assign phi2_rise = phi2 & ~phi2_prev_reg;
  assign phi2_fall = ~phi2 & phi2_prev_reg;

  // ---------------------------------------------------------------------------
  // Bus-phase capture: the last values seen while PHI2 is high are committed
  // ---------------------------------------------------------------------------
  logic [15:0] live_off;
  logic        live_hit;
  logic        phase_reg;
  logic        bus_rw_reg;
  logic        bus_hit_reg;
  logic [2:0]  bus_off_reg;
  logic [7:0]  bus_wdata_reg;
  logic        commit;

  assign live_off = i_64addr - BASE_ADDR;
  assign live_hit = (live_off < 16'd6);
  assign commit   = phi2_fall & phase_reg;

  // Track the open bus phase and sample the C64 bus while PHI2 is high
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      phi2_prev_reg <= 1'b0;
      phase_reg     <= 1'b0;
      bus_rw_reg    <= 1'b1;
      bus_hit_reg   <= 1'b0;
      bus_off_reg   <= 3'd0;
      bus_wdata_reg <= 8'h00;
    end else begin
      phi2_prev_reg <= phi2;
      if (phi2_rise)      phase_reg <= 1'b1;
      else if (phi2_fall) phase_reg <= 1'b0;
      if (phi2) begin
        bus_rw_reg    <= i_64rw;
        bus_hit_reg   <= live_hit;
        bus_off_reg   <= live_off[2:0];
        bus_wdata_reg <= i_64data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------
  logic [7:0]  token_reg, token_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  buffer_reg;
  logic        valid_reg;
  logic        underrun_reg;
  logic        pending_reg;
  logic [1:0]  state_reg;
  logic [16:0] rd_addr_reg;
  logic        launch;
  logic        set_underrun;
  logic        clr_underrun;
  logic [16:0] fetch_addr;
  logic        fill;
  logic [7:0]  status;

  // Decode the committed access into register updates and a prefetch launch
  always_comb begin
    token_next   = token_reg;
    addr_next    = addr_reg;
    launch       = 1'b0;
    set_underrun = 1'b0;
    clr_underrun = 1'b0;
    if (commit && bus_hit_reg) begin
      if (!bus_rw_reg) begin
        case (bus_off_reg)
          OFF_TOKEN: begin
            token_next = bus_wdata_reg;
            launch     = 1'b1;
          end
          OFF_ADDR_L: begin
            addr_next[7:0] = bus_wdata_reg;
            launch         = 1'b1;
          end
          OFF_ADDR_H: begin
            addr_next[15:8] = bus_wdata_reg;
            launch          = 1'b1;
          end
          OFF_OPER:   launch = 1'b1;
          default:    ;
        endcase
      end else begin
        case (bus_off_reg)
          OFF_DATA: begin
            if (valid_reg) begin
              addr_next = addr_reg + 16'd1;
              launch    = 1'b1;
            end else begin
              set_underrun = 1'b1;
            end
          end
          OFF_STATUS: clr_underrun = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // The fetch address always reflects this cycle's commit (e.g. the bumped pointer)
  assign fetch_addr = {token_next[0], addr_next};

  // A fill lands only when nothing newer has been asked for
  assign fill = (state_reg == ST_WAIT) && i_rd_valid && !pending_reg && !launch;

  // Token/address/status registers updated by commits and fills
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      token_reg    <= 8'h00;
      addr_reg     <= 16'h0000;
      buffer_reg   <= 8'h00;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      token_reg <= token_next;
      addr_reg  <= addr_next;
      if (fill) buffer_reg <= i_rd_data;
      if (launch)    valid_reg <= 1'b0;
      else if (fill) valid_reg <= 1'b1;
      if (set_underrun)      underrun_reg <= 1'b1;
      else if (clr_underrun) underrun_reg <= 1'b0;
    end
  end

  // Prefetch FSM: request the read slot, wait for data, restart if superseded
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      rd_addr_reg <= 17'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            rd_addr_reg <= fetch_addr;
            state_reg   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_rd_gnt) begin
            // Slot already granted for the old address: refetch after the data
            state_reg <= ST_WAIT;
            if (launch) pending_reg <= 1'b1;
          end else if (launch) begin
            rd_addr_reg <= fetch_addr;
          end
        end
        ST_WAIT: begin
          if (i_rd_valid) begin
            if (pending_reg || launch) begin
              rd_addr_reg <= fetch_addr;
              pending_reg <= 1'b0;
              state_reg   <= ST_REQ;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else if (launch) begin
            pending_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_req  = (state_reg == ST_REQ);
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_rd_addr = rd_addr_reg;
  assign status    = {5'b00000, underrun_reg, o_busy, valid_reg};

  // Drive the C64 bus for readable registers while synced PHI2 is high
  always_comb begin
    o_64doe  = 1'b0;
    o_64data = 8'h00;
    if (phi2 && i_64rw && live_hit) begin
      case (live_off[2:0])
        OFF_TOKEN:  begin o_64doe = 1'b1; o_64data = token_reg;       end
        OFF_ADDR_L: begin o_64doe = 1'b1; o_64data = addr_reg[7:0];   end
        OFF_ADDR_H: begin o_64doe = 1'b1; o_64data = addr_reg[15:8];  end
        OFF_DATA:   begin o_64doe = 1'b1; o_64data = buffer_reg;      end
        OFF_STATUS: begin o_64doe = 1'b1; o_64data = status;          end
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_readback.sv
// tb_vram_readback: directed + randomized checks of vram_readback against a
// register-level model of the C64 window and a simple SRAM/arbiter model.
`timescale 1ns/1ps

module tb_vram_readback;

  localparam logic [15:0] BASE = 16'hDE00;
  localparam int SYNC = 2;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        i_64clk;
  logic        i_64rw;
  logic [15:0] i_64addr;
  logic [7:0]  i_64data;
  logic [7:0]  o_64data;
  logic        o_64doe;
  logic        o_rd_req;
  logic        i_rd_gnt;
  logic [16:0] o_rd_addr;
  logic        i_rd_valid;
  logic [7:0]  i_rd_data;
  logic        o_busy;

  vram_readback #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk100(clk100), .rst(rst), .i_64clk(i_64clk), .i_64rw(i_64rw),
    .i_64addr(i_64addr), .i_64data(i_64data), .o_64data(o_64data),
    .o_64doe(o_64doe), .o_rd_req(o_rd_req), .i_rd_gnt(i_rd_gnt),
    .o_rd_addr(o_rd_addr), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_busy(o_busy)
  );

  always #5 clk100 = ~clk100;

  // SRAM contents and arbiter controls
  logic [7:0]  mem [0:131071];
  logic        arb_en = 1'b1;
  int          fixed_vdly = 0;
  int          inject_req = 0;
  logic [16:0] gnt_q [$];

  // Reference model of the register window
  logic [7:0]  m_token;
  logic [15:0] m_addr;
  logic [7:0]  m_buf;
  logic        m_valid, m_under, m_fetch;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arbiter: grants after a short random delay, returns mem[] of the granted address
  initial begin : arbiter
    int a_cnt;
    int inject_done;
    logic a_busy;
    logic [16:0] gaddr;
    a_cnt = 0; inject_done = 0; a_busy = 1'b0; gaddr = '0;
    i_rd_gnt = 1'b0; i_rd_valid = 1'b0; i_rd_data = 8'h00;
    forever begin
      @(posedge clk100); #1;
      i_rd_gnt = 1'b0;
      i_rd_valid = 1'b0;
      if (rst) begin
        a_busy = 1'b0;
        a_cnt = 0;
      end else if (inject_req != inject_done) begin
        inject_done = inject_req;
        i_rd_valid = 1'b1;
        i_rd_data = 8'h5A;
      end else if (!a_busy) begin
        if (o_rd_req && arb_en) begin
          if (a_cnt == 0) begin
            i_rd_gnt = 1'b1;
            gaddr = o_rd_addr;
            gnt_q.push_back(gaddr);
            a_busy = 1'b1;
            a_cnt = (fixed_vdly != 0) ? fixed_vdly : int'($urandom_range(1, 6));
          end else a_cnt--;
        end
      end else begin
        if (a_cnt == 0) begin
          i_rd_valid = 1'b1;
          i_rd_data = mem[gaddr];
          a_busy = 1'b0;
          a_cnt = int'($urandom_range(0, 4));
        end else a_cnt--;
      end
    end
  end

  // One C64 bus cycle: PHI2 low, high (sample drive), low (check release)
  task automatic bus_cycle(input logic rw, input logic [2:0] off, input logic [7:0] wd,
                           output logic doe_hi, output logic [7:0] rd_hi, output logic doe_lo);
    i_64rw = rw; i_64addr = BASE + {13'd0, off}; i_64data = wd;
    repeat (4) @(posedge clk100); #1;
    i_64clk = 1'b1;
    repeat (SYNC + 2) @(posedge clk100); #1;
    doe_hi = o_64doe; rd_hi = o_64data;
    repeat (6) @(posedge clk100); #1;
    i_64clk = 1'b0;
    repeat (SYNC + 1) @(posedge clk100); #1;
    doe_lo = o_64doe;
    repeat (4) @(posedge clk100); #1;
    i_64rw = 1'b1; i_64addr = 16'h0000; i_64data = 8'h00;
  endtask

  task automatic model_reset();
    m_token = 8'h00; m_addr = 16'h0000; m_buf = 8'h00;
    m_valid = 1'b0; m_under = 1'b0; m_fetch = 1'b0;
  endtask

  // Wait for any outstanding prefetch to land, then fill the model buffer
  task automatic settle(input int bound);
    int i;
    if (arb_en) begin
      for (i = 0; i < bound; i++) begin
        @(posedge clk100); #1;
        if (!o_busy) break;
      end
      chk("settle_timeout", {31'd0, o_busy}, 32'd0);
      if (m_fetch) begin
        m_valid = 1'b1;
        m_buf = mem[{m_token[0], m_addr}];
        m_fetch = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [2:0] off, input logic [7:0] val);
    logic dh, dl; logic [7:0] rd;
    bus_cycle(1'b0, off, val, dh, rd, dl);
    chk($sformatf("wr%0d_doe", off), {31'd0, dh}, 32'd0);
    chk($sformatf("wr%0d_doe_lo", off), {31'd0, dl}, 32'd0);
    case (off)
      3'd0: m_token = val;
      3'd1: m_addr[7:0] = val;
      3'd2: m_addr[15:8] = val;
      default: ;
    endcase
    m_valid = 1'b0;
    m_fetch = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] off, input string tag);
    logic dh, dl; logic [7:0] rd, exp;
    case (off)
      3'd0: exp = m_token;
      3'd1: exp = m_addr[7:0];
      3'd2: exp = m_addr[15:8];
      3'd4: exp = m_buf;
      default: exp = {5'd0, m_under, m_fetch, m_valid};
    endcase
    bus_cycle(1'b1, off, 8'h00, dh, rd, dl);
    chk({tag, "_doe"}, {31'd0, dh}, 32'd1);
    chk({tag, "_data"}, {24'd0, rd}, {24'd0, exp});
    chk({tag, "_doe_lo"}, {31'd0, dl}, 32'd0);
    if (off == 3'd4) begin
      if (m_valid) begin
        m_addr = m_addr + 16'd1;
        m_valid = 1'b0;
        m_fetch = 1'b1;
      end else m_under = 1'b1;
    end else if (off == 3'd5) m_under = 1'b0;
  endtask

  initial begin : main
    int g;
    int op;
    rst = 1'b1; i_64clk = 1'b0; i_64rw = 1'b1; i_64addr = 16'h0000; i_64data = 8'h00;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[17'h11234] = 8'hA5;
    mem[17'h02000] = 8'h11;
    mem[17'h02055] = 8'h22;
    model_reset();

    // Reset state
    repeat (5) @(posedge clk100); #1;
    chk("rst_data", {24'd0, o_64data}, 32'd0);
    chk("rst_doe", {31'd0, o_64doe}, 32'd0);
    chk("rst_req", {31'd0, o_rd_req}, 32'd0);
    chk("rst_addr", {15'd0, o_rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk100); #1;
    chk("no_prefetch_after_rst", {31'd0, o_busy}, 32'd0);
    do_read(3'd5, "rst_status");

    // Basic read-back (writes back to back, so later ones may restart earlier fetches)
    do_write(3'd1, 8'h34);
    do_write(3'd2, 8'h12);
    do_write(3'd0, 8'h01);
    settle(200);
    chk("basic_rd_addr", {15'd0, o_rd_addr}, 32'h11234);
    do_read(3'd5, "basic_status");
    do_read(3'd4, "basic_data");
    settle(200);
    chk("basic_next_addr", {15'd0, o_rd_addr}, 32'h11235);
    do_read(3'd1, "basic_addr_lo");
    do_read(3'd0, "basic_token");

    // Wrap, bank 0 then bank 1
    do_write(3'd1, 8'hFF); do_write(3'd2, 8'hFF); do_write(3'd0, 8'h00);
    settle(200);
    do_read(3'd4, "wrap0_data");
    settle(200);
    chk("wrap0_addr", {15'd0, o_rd_addr}, 32'h00000);
    do_write(3'd1, 8'hFF); do_write(3'd2, 8'hFF); do_write(3'd0, 8'h01);
    settle(200);
    do_read(3'd4, "wrap1_data");
    settle(200);
    chk("wrap1_addr", {15'd0, o_rd_addr}, 32'h10000);
    do_read(3'd2, "wrap1_addr_hi");

    // Underrun with the read slot withheld; second launch updates the request in place
    arb_en = 1'b0;
    do_write(3'd1, 8'h80);
    chk("ur_req", {31'd0, o_rd_req}, 32'd1);
    chk("ur_addr1", {15'd0, o_rd_addr}, {15'd0, m_token[0], m_addr});
    do_write(3'd1, 8'h81);
    chk("ur_addr_inplace", {15'd0, o_rd_addr}, {15'd0, m_token[0], m_addr});
    do_read(3'd4, "ur_stale");
    chk("ur_ptr_kept", {15'd0, o_rd_addr}, {15'd0, m_token[0], m_addr});
    do_read(3'd5, "ur_status_set");
    do_read(3'd5, "ur_status_clr");
    arb_en = 1'b1;
    g = gnt_q.size();
    settle(200);
    chk("ur_one_fetch", g + 1, gnt_q.size());
    chk("ur_fetch_addr", {15'd0, gnt_q[gnt_q.size()-1]}, {15'd0, m_token[0], m_addr});
    do_read(3'd4, "ur_data");
    settle(200);

    // Restart: retarget while the first fetch is waiting for data
    do_write(3'd2, 8'h20); do_write(3'd1, 8'h00); do_write(3'd0, 8'h00);
    settle(200);
    fixed_vdly = 40;
    g = gnt_q.size();
    do_write(3'd3, 8'h00);
    do_write(3'd1, 8'h55);
    chk("rs_busy", {31'd0, o_busy}, 32'd1);
    chk("rs_addr_held", {15'd0, o_rd_addr}, 32'h02000);
    settle(400);
    fixed_vdly = 0;
    chk("rs_two_fetches", g + 2, gnt_q.size());
    chk("rs_first_addr", {15'd0, gnt_q[gnt_q.size()-2]}, 32'h02000);
    chk("rs_second_addr", {15'd0, gnt_q[gnt_q.size()-1]}, 32'h02055);
    do_read(3'd4, "rs_data");
    settle(200);

    // Coherency: operand write refetches the same address
    arb_en = 1'b0;
    do_write(3'd3, 8'h77);
    do_read(3'd5, "coh_status");
    arb_en = 1'b1;
    g = gnt_q.size();
    settle(200);
    chk("coh_refetch", g + 1, gnt_q.size());
    chk("coh_addr", {15'd0, gnt_q[gnt_q.size()-1]}, {15'd0, m_token[0], m_addr});
    do_read(3'd5, "coh_status_valid");

    // Randomized register traffic
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 6));
      if (op <= 3) do_write(3'(op), 8'($urandom));
      else if (op == 4) do_read(3'd4, $sformatf("rnd%0d_data", k));
      else if (op == 5) do_read(3'd5, $sformatf("rnd%0d_status", k));
      else do_read(3'($urandom_range(0, 2)), $sformatf("rnd%0d_reg", k));
      settle(200);
    end

    // Asynchronous reset mid-REQ, then a stray data strobe must be ignored
    arb_en = 1'b0;
    do_write(3'd1, 8'h40);
    chk("arst_pre_req", {31'd0, o_rd_req}, 32'd1);
    @(posedge clk100); #3;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, o_rd_req}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk100); #1;
    chk("arst_addr", {15'd0, o_rd_addr}, 32'd0);
    chk("arst_doe", {31'd0, o_64doe}, 32'd0);
    chk("arst_data", {24'd0, o_64data}, 32'd0);
    rst = 1'b0;
    model_reset();
    arb_en = 1'b1;
    inject_req++;
    repeat (4) @(posedge clk100); #1;
    chk("arst_idle", {31'd0, o_busy}, 32'd0);
    do_read(3'd5, "arst_status");
    do_read(3'd4, "arst_buffer");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
